// File: rtl/grf_wb.sv
// ---------------------------------------------------------------------------
// grf_wb -- 32 x 32-bit general register file for the single-cycle MIPS
// datapath, placed directly after the write-back data select mux.
//
// Ports:
//   clk       in   system clock; all state updates on the rising edge
//   reset     in   synchronous active-high reset (wins over WE)
//   A1, A2    in   read port indices (rs, rt)
//   A3        in   write index from the destination select mux
//   WD        in   write data from the write-back mux
//   WE        in   write enable (RegWrite)
//   PC        in   PC of the writing instruction, captured for trace
//   RD1, RD2  out  combinational read data with write-first bypass
//   wr_valid  out  one-cycle pulse after each committed write
//   wr_pc     out  PC of the last committed write
//   wr_addr   out  register index of the last committed write
//   wr_data   out  data of the last committed write
//   wr_count  out  committed writes since reset, wraps modulo 2^CNTW
// ---------------------------------------------------------------------------
module grf_wb #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      A1,
  input  logic [4:0]      A2,
  input  logic [4:0]      A3,
  input  logic [DW-1:0]   WD,
  input  logic            WE,
  input  logic [31:0]     PC,
  output logic [DW-1:0]   RD1,
  output logic [DW-1:0]   RD2,
  output logic            wr_valid,
  output logic [31:0]     wr_pc,
  output logic [4:0]      wr_addr,
  output logic [DW-1:0]   wr_data,
  output logic [CNTW-1:0] wr_count
);

  logic [DW-1:0]   regs_q [NREG];
  logic            wr_valid_q;
  logic [31:0]     wr_pc_q;
  logic [4:0]      wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic [CNTW-1:0] wr_count_q;
  logic [CNTW-1:0] wr_count_d;

  // Writes to $0 and writes coinciding with reset are dropped entirely:
  // not stored, not traced, not counted.
  logic commit;
  assign commit = WE && (A3 != 5'd0) && !reset;

  // Bypass uses the same qualification as commit, so a read never shows a
  // value that will not actually be stored.
  logic byp1, byp2;
  assign byp1 = commit && (A3 == A1);
  assign byp2 = commit && (A3 == A2);

  assign wr_count_d = wr_count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q     <= '{default: '0};
      wr_valid_q <= 1'b0;
      wr_pc_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
    end else begin
      // An X on WE makes commit non-true, so it falls to the no-write path.
      if (commit) begin
        regs_q[A3] <= WD;
        wr_valid_q <= 1'b1;
        wr_pc_q    <= PC;
        wr_addr_q  <= A3;
        wr_data_q  <= WD;
        wr_count_q <= wr_count_d;
      end else begin
        wr_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    RD1 = '0;
    if (A1 == 5'd0)  RD1 = '0;
    else if (byp1)   RD1 = WD;
    else             RD1 = regs_q[A1];
  end

  always_comb begin
    RD2 = '0;
    if (A2 == 5'd0)  RD2 = '0;
    else if (byp2)   RD2 = WD;
    else             RD2 = regs_q[A2];
  end

  assign wr_valid = wr_valid_q;
  assign wr_pc    = wr_pc_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_grf_wb.sv
// ---------------------------------------------------------------------------
// tb_grf_wb -- self-checking bench for grf_wb. A directed vector table covers
// reset state, writes, $0 handling, bypass, back-to-back writes and reset
// priority; a long sequence covers counter wrap and full readback.
// ---------------------------------------------------------------------------
module tb_grf_wb;

  logic        clk;
  logic        reset;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD, PC;
  logic        WE;
  logic [31:0] RD1, RD2;
  logic        wr_valid;
  logic [31:0] wr_pc;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] wr_count;

  int checks;
  int failures;

  grf_wb #(.NREG(32), .DW(32), .CNTW(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .A1       (A1),
    .A2       (A2),
    .A3       (A3),
    .WD       (WD),
    .WE       (WE),
    .PC       (PC),
    .RD1      (RD1),
    .RD2      (RD2),
    .wr_valid (wr_valid),
    .wr_pc    (wr_pc),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  a1, a2, a3;
    logic [31:0] wd, pc;
    logic [31:0] e_rd1, e_rd2;   // before the edge
    logic        e_valid;        // after the edge
    logic [4:0]  e_addr;
    logic [31:0] e_data, e_pc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(logic rst, logic we, logic [4:0] a1, logic [4:0] a2,
                              logic [4:0] a3, logic [31:0] wd, logic [31:0] pc,
                              logic [31:0] r1, logic [31:0] r2, logic v,
                              logic [4:0] ea, logic [31:0] ed, logic [31:0] ep,
                              logic [15:0] ec);
    vec_t t;
    t.rst = rst; t.we = we; t.a1 = a1; t.a2 = a2; t.a3 = a3; t.wd = wd; t.pc = pc;
    t.e_rd1 = r1; t.e_rd2 = r2; t.e_valid = v; t.e_addr = ea; t.e_data = ed;
    t.e_pc = ep; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  logic [31:0] shadow [32];
  int          bad_valid;
  logic [31:0] d;
  logic [4:0]  r;

  initial begin
    checks = 0; failures = 0;
    //        rst we  a1  a2  a3  wd            pc             rd1           rd2           v  addr ddata         dpc           cnt
    vt[0]  = mk(0, 0, 5,  31, 0,  32'h0,        32'h0,         32'h0,        32'h0,        0, 0,  32'h0,        32'h0,        16'd0);
    vt[1]  = mk(0, 1, 8,  0,  8,  32'h12345678, 32'h00003000,  32'h12345678, 32'h0,        1, 8,  32'h12345678, 32'h00003000, 16'd1);
    vt[2]  = mk(0, 0, 8,  8,  0,  32'h0,        32'h0,         32'h12345678, 32'h12345678, 0, 8,  32'h12345678, 32'h00003000, 16'd1);
    vt[3]  = mk(0, 1, 0,  8,  0,  32'hFFFFFFFF, 32'h00003004,  32'h0,        32'h12345678, 0, 8,  32'h12345678, 32'h00003000, 16'd1);
    vt[4]  = mk(0, 0, 0,  8,  0,  32'hFFFFFFFF, 32'h0,         32'h0,        32'h12345678, 0, 8,  32'h12345678, 32'h00003000, 16'd1);
    vt[5]  = mk(0, 1, 9,  8,  9,  32'h00000001, 32'h00003008,  32'h00000001, 32'h12345678, 1, 9,  32'h00000001, 32'h00003008, 16'd2);
    vt[6]  = mk(0, 0, 0,  9,  9,  32'hDEADBEEF, 32'h0000300C,  32'h0,        32'h00000001, 0, 9,  32'h00000001, 32'h00003008, 16'd2);
    vt[7]  = mk(0, 1, 9,  9,  9,  32'hDEADBEEF, 32'h0000300C,  32'hDEADBEEF, 32'hDEADBEEF, 1, 9,  32'hDEADBEEF, 32'h0000300C, 16'd3);
    vt[8]  = mk(0, 1, 9,  8,  9,  32'hCAFEF00D, 32'h00003010,  32'hCAFEF00D, 32'h12345678, 1, 9,  32'hCAFEF00D, 32'h00003010, 16'd4);
    vt[9]  = mk(0, 0, 9,  9,  0,  32'h0,        32'h0,         32'hCAFEF00D, 32'hCAFEF00D, 0, 9,  32'hCAFEF00D, 32'h00003010, 16'd4);
    vt[10] = mk(1, 1, 4,  9,  4,  32'h000000AA, 32'h00003014,  32'h0,        32'hCAFEF00D, 0, 0,  32'h0,        32'h0,        16'd0);
    vt[11] = mk(0, 0, 4,  9,  0,  32'h0,        32'h0,         32'h0,        32'h0,        0, 0,  32'h0,        32'h0,        16'd0);
    vt[12] = mk(0, 1, 4,  0,  4,  32'h000000AA, 32'h00003014,  32'h000000AA, 32'h0,        1, 4,  32'h000000AA, 32'h00003014, 16'd1);
    vt[13] = mk(0, 0, 4,  8,  0,  32'h0,        32'h0,         32'h000000AA, 32'h0,        0, 4,  32'h000000AA, 32'h00003014, 16'd1);
    vt[14] = mk(0, 1, 31, 31, 31, 32'h80000001, 32'hFFFFFFFC,  32'h80000001, 32'h80000001, 1, 31, 32'h80000001, 32'hFFFFFFFC, 16'd2);
    vt[15] = mk(0, 0, 31, 4,  0,  32'h0,        32'h0,         32'h80000001, 32'h000000AA, 0, 31, 32'h80000001, 32'hFFFFFFFC, 16'd2);

    reset = 1'b1; WE = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD = '0; PC = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      reset = vt[i].rst; WE = vt[i].we; A1 = vt[i].a1; A2 = vt[i].a2;
      A3 = vt[i].a3; WD = vt[i].wd; PC = vt[i].pc;
      #1;
      chk($sformatf("v%0d_rd1", i), RD1, vt[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), RD2, vt[i].e_rd2);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, wr_valid}, {31'd0, vt[i].e_valid});
      chk($sformatf("v%0d_addr", i),  {27'd0, wr_addr},  {27'd0, vt[i].e_addr});
      chk($sformatf("v%0d_data", i),  wr_data, vt[i].e_data);
      chk($sformatf("v%0d_pc", i),    wr_pc,   vt[i].e_pc);
      chk($sformatf("v%0d_cnt", i),   {16'd0, wr_count}, {16'd0, vt[i].e_cnt});
    end

    // Counter wrap: fresh reset, then 65536 committed writes over regs 1..31.
    @(negedge clk);
    reset = 1'b1; WE = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 32; k++) shadow[k] = '0;
    bad_valid = 0;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      r = 5'((i % 31) + 1);
      d = (i * 32'h9E3779B9) ^ 32'h5A5A0000;
      WE = 1'b1; A3 = r; WD = d; PC = i * 4;
      @(posedge clk);
      shadow[r] = d;
      #1;
      if (wr_valid !== 1'b1) bad_valid++;
      if (i == 65534) chk("cnt_ffff", {16'd0, wr_count}, 32'h0000FFFF);
    end
    chk("wrap_valid_each_write", bad_valid, 0);
    @(negedge clk);
    WE = 1'b0;
    #1;
    chk("cnt_wrap_zero", {16'd0, wr_count}, 32'h0);
    chk("wrap_last_addr", {27'd0, wr_addr}, {27'd0, 5'((65535 % 31) + 1)});
    for (int k = 0; k < 32; k++) begin
      A1 = 5'(k); A2 = 5'(31 - k);
      #1;
      chk($sformatf("rb_rd1_r%0d", k), RD1, shadow[k]);
      chk($sformatf("rb_rd2_r%0d", 31 - k), RD2, shadow[31 - k]);
    end
    @(posedge clk);
    #1;
    chk("idle_valid_low", {31'd0, wr_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grf_wb.md
Name: grf_wb

Overview:
- 32 x 32-bit general register file for the single-cycle MIPS datapath.
- Sits directly downstream of the 4:1 32-bit write-back data select mux, which chooses among ALU result, DM read data, PC+4 and LUI immediate.
- Consumes that mux output as write data, plus a 5-bit destination select.
- Provides two combinational read ports with write-first bypass, a last-write trace record, and a retired-write counter for the bench.

Parameters:
- NREG, 32, number of registers (index width fixed at 5).
- DW, 32, data width.
- CNTW, 16, width of the retired-write counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- A1  input  5  read port 1 register index (rs).
- A2  input  5  read port 2 register index (rt).
- A3  input  5  write register index, from the destination select mux.
- WD  input  32  write data, from the write-back data mux.
- WE  input  1  write enable (RegWrite).
- PC  input  32  PC of the instruction performing the write, for trace.
- RD1  output  32  read data, port 1.
- RD2  output  32  read data, port 2.
- wr_valid  output  1  pulses for one cycle after a committed write.
- wr_pc  output  32  PC of the last committed write.
- wr_addr  output  5  register index of the last committed write.
- wr_data  output  32  data of the last committed write.
- wr_count  output  CNTW  number of committed writes since reset.

Behaviour:
- Storage: regs[0..31], each 32 bits. regs[0] is constant 0 and is never written.
- Reset:
  - When reset=1 at a rising edge, all regs become 0.
  - wr_valid, wr_pc, wr_addr, wr_data and wr_count become 0.
  - Reset has priority over WE. A write presented in the same cycle as reset is discarded and is not counted.
- Commit condition: commit = WE && (A3 != 0) && !reset.
  - On a rising edge with commit=1: regs[A3] <= WD.
  - Trace registers load: wr_pc <= PC, wr_addr <= A3, wr_data <= WD, wr_valid <= 1.
  - wr_count <= wr_count + 1.
- No commit: if WE=0 or A3=0 at an edge (and not reset), regs are unchanged, wr_valid <= 0, and wr_pc/wr_addr/wr_data hold their values.
- $0 writes: WE=1 with A3=0 is silently ignored. It is not traced and not counted.
- Counter wrap: wr_count wraps modulo 2^CNTW (0xFFFF + 1 -> 0x0000) with no saturation and no flag.
- Reads:
  - Purely combinational, zero latency.
  - RD1 = 0 if A1 = 0.
  - Else RD1 = WD if (WE && A3 == A1 && !reset), the write-first bypass.
  - Else RD1 = regs[A1].
  - RD2 follows the same rule using A2.
- Bypass scope: the bypass is combinational from current WD/WE/A3. With the single-cycle datapath this yields the same-cycle value.
- Same-port reads: A1 == A2 is legal and both ports return identical values.
- Back-to-back writes: consecutive writes to the same register keep the last value; each one is counted and traced.
- Width rules: no sign extension or truncation inside the block; all data paths are exactly DW bits.
- X handling: WE=X must not be treated as a write. The bench drives known values on WE at all times after reset.

Test Plan:
- Reset, then set A1=5, A2=31 -> RD1=RD2=0, wr_count=0, wr_valid=0.
- WE=1, A3=8, WD=0x12345678, PC=0x00003000, one edge:
  - wr_valid=1 for exactly one cycle; wr_pc=0x3000, wr_addr=8, wr_data=0x12345678, wr_count=1.
  - After the edge, A1=8 -> RD1=0x12345678.
- WE=1, A3=0, WD=0xFFFFFFFF, with A1=0 -> RD1=0 before and after the edge; wr_count unchanged; wr_valid=0.
- Bypass: reg9 holds 0x1. Set A2=9, WE=1, A3=9, WD=0xDEADBEEF -> RD2=0xDEADBEEF combinationally before the edge. With WE=0 instead, RD2=0x1.
- Reset priority: reset=1, WE=1, A3=4, WD=0xAA at one edge -> reg4=0, wr_count=0, wr_valid=0. Deassert reset and confirm a normal write to reg4 then succeeds.
- Counter wrap: perform 65536 committed writes to a cycling set of registers 1..31 -> wr_count returns to 0x0000, and every register read back equals its last written value.
